// File: rtl/mult_f32_iter.sv
// rtl/mult_f32_iter.sv - iterative float32 multiplier, radix-2 shift-add mantissa engine
// Specials resolve on the accept edge; normal operands take 24 MULT cycles plus one NORM cycle.
module mult_f32_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        rdy,
  output logic [31:0] m
);

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

  state_t             state, state_nxt;
  logic [23:0]        ma, mb;
  logic               s;
  logic signed [9:0]  e;
  logic [47:0]        acc;
  logic [4:0]         cnt;

  logic [7:0]         ea, eb;
  logic [22:0]        fa, fb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic               special, accept, op_s;
  logic [31:0]        spec_m;
  logic signed [9:0]  op_e;

  assign ea = a[30:23];
  assign eb = b[30:23];
  assign fa = a[22:0];
  assign fb = b[22:0];

  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);

  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign op_s    = a[31] ^ b[31];
  assign op_e    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

  // Denormal operands count as zero, so inf x denormal is an invalid operation too.
  always_comb begin
    spec_m = {op_s, 31'd0};
    if (a_nan || b_nan)
      spec_m = 32'h7FC00000;
    else if ((a_inf && b_zero) || (b_inf && a_zero))
      spec_m = 32'h7FC00000;
    else if (a_inf || b_inf)
      spec_m = {op_s, 8'hFF, 23'd0};
  end

  logic [47:0]        addend;
  logic [22:0]        n_mant;
  logic               n_guard, n_sticky, n_inc;
  logic signed [9:0]  n_e, r_e;
  logic [23:0]        n_rnd;
  logic [22:0]        r_frac;
  logic [31:0]        norm_m;

  assign addend = mb[cnt] ? ({24'd0, ma} << cnt) : 48'd0;

  always_comb begin
    if (acc[47]) begin
      n_mant   = acc[46:24];
      n_guard  = acc[23];
      n_sticky = |acc[22:0];
      n_e      = e + 10'sd1;
    end else begin
      n_mant   = acc[45:23];
      n_guard  = acc[22];
      n_sticky = |acc[21:0];
      n_e      = e;
    end
    n_inc  = n_guard & (n_sticky | n_mant[0]);
    n_rnd  = {1'b0, n_mant} + {23'd0, n_inc};
    r_e    = n_rnd[23] ? (n_e + 10'sd1) : n_e;
    r_frac = n_rnd[23] ? 23'd0 : n_rnd[22:0];
    if (r_e >= 10'sd255)
      norm_m = {s, 8'hFF, 23'd0};
    else if (r_e <= 10'sd0)
      norm_m = {s, 31'd0};
    else
      norm_m = {s, r_e[7:0], r_frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = special ? DONE : MULT;
      MULT:       if (cnt == 5'd0) state_nxt = NORM;
      NORM:       state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma  <= 24'd0;
      mb  <= 24'd0;
      s   <= 1'b0;
      e   <= 10'sd0;
      acc <= 48'd0;
      cnt <= 5'd0;
      m   <= 32'd0;
    end else if (accept) begin
      ma  <= {1'b1, fa};
      mb  <= {1'b1, fb};
      s   <= op_s;
      e   <= op_e;
      acc <= 48'd0;
      cnt <= 5'd23;
      if (special)
        m <= spec_m;
    end else if (state == MULT) begin
      acc <= acc + addend;
      cnt <= cnt - 5'd1;
    end else if (state == NORM) begin
      m <= norm_m;
    end
  end

  assign busy = (state == MULT) || (state == NORM);
  assign rdy  = (state == DONE);

endmodule

// File: tb/tb_mult_f32_iter.sv
// tb/tb_mult_f32_iter.sv - scoreboard bench for mult_f32_iter
// Directed cases plus random operands checked against an integer-product reference model.
module tb_mult_f32_iter;

  logic        clk, rst, start;
  logic [31:0] a, b;
  logic        busy, rdy;
  logic [31:0] m;

  mult_f32_iter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .rdy   (rdy),
    .m     (m)
  );

  typedef struct {
    logic [31:0] exp_m;
    int          lat;
    int          c0;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle    = 0;
  int          n_issued = 0;
  int          n_seen   = 0;
  logic        rdy_prev = 1'b0;
  logic [31:0] held_m   = 32'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic is_special(input logic [31:0] x);
    return (x[30:23] == 8'hFF) || (x[30:23] == 8'h00);
  endfunction

  // Reference: exact 48-bit product, then round-to-nearest-even by remainder comparison.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic            sg;
    int              ex, ey, e, sh;
    logic [22:0]     fx, fy;
    longint unsigned p, mant, rem, half;
    sg = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = x[22:0];
    fy = y[22:0];
    if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0)) return 32'h7FC00000;
    if ((ex == 255 && ey == 0) || (ey == 255 && ex == 0)) return 32'h7FC00000;
    if (ex == 255 || ey == 255) return {sg, 8'hFF, 23'd0};
    if (ex == 0 || ey == 0) return {sg, 31'd0};
    p = 64'({1'b1, fx}) * 64'({1'b1, fy});
    e = ex + ey - 127;
    if ((p >> 47) != 0) begin
      e++;
      sh = 24;
    end else begin
      sh = 23;
    end
    mant = (p >> sh) & 64'h7FFFFF;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && mant[0])) mant++;
    if (mant == 64'h800000) begin
      mant = 0;
      e++;
    end
    if (e >= 255) return {sg, 8'hFF, 23'd0};
    if (e <= 0) return {sg, 31'd0};
    return {sg, 8'(e), mant[22:0]};
  endfunction

  // Call away from a rising edge; returns just after the accept edge.
  task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] exp);
    exp_t t;
    start = 1'b1;
    a = xa;
    b = xb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    t.exp_m = exp;
    t.lat   = is_special(xa) || is_special(xb) ? 1 : 26;
    t.c0    = cycle;
    q.push_back(t);
    n_issued++;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d results still pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic run(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] exp);
    issue(xa, xb, exp);
    wait_done();
  endtask

  initial begin : monitor
    logic new_acc;
    exp_t t;
    forever begin
      @(negedge clk);
      new_acc = (n_issued != n_seen);
      n_seen  = n_issued;
      if (!rst) begin
        check("rdy_busy_excl", {31'd0, rdy && busy}, 32'd0);
        if (rdy && (!rdy_prev || new_acc)) begin
          if (q.size() == 0) begin
            check("unexpected_rdy", 32'd1, 32'd0);
          end else begin
            t = q.pop_front();
            check("m", m, t.exp_m);
            check("latency", 32'(cycle - t.c0 + 1), 32'(t.lat));
            held_m = m;
          end
        end else if (q.size() > 0 && q[0].lat == 26) begin
          check("busy_during_op", {31'd0, busy}, 32'd1);
          check("rdy_during_op", {31'd0, rdy}, 32'd0);
          check("m_hold", m, held_m);
        end
      end
      rdy_prev = rdy;
    end
  end

  initial begin
    logic [31:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdy", {31'd0, rdy}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_m", m, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;

    run(32'h40000000, 32'h40400000, 32'h40C00000);
    run(32'h3FC00000, 32'h3FC00000, 32'h40100000);
    run(32'h3F800001, 32'h3F800001, 32'h3F800002);
    run(32'hBF800000, 32'h00000000, 32'h80000000);
    run(32'h7F800000, 32'h00000000, 32'h7FC00000);
    run(32'hFF800000, 32'h40000000, 32'hFF800000);
    run(32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    run(32'h7F000000, 32'h7F000000, 32'h7F800000);
    run(32'h00800000, 32'h00800000, 32'h00000000);
    run(32'h00400000, 32'h40000000, 32'h00000000);

    // start while busy must be ignored
    issue(32'h40000000, 32'h40400000, 32'h40C00000);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1;
    a = 32'h3F800000;
    b = 32'h41200000;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // back-to-back from DONE, including special after normal and normal after special
    issue(32'hC0000000, 32'h40800000, 32'hC1000000);
    wait_done();
    issue(32'h40400000, 32'h40400000, 32'h41100000);
    wait_done();
    issue(32'h7F800000, 32'h3F800000, 32'h7F800000);
    wait_done();
    issue(32'h3F800000, 32'hBF800000, 32'hBF800000);
    wait_done();

    // reset in the middle of a multiply
    issue(32'h40000000, 32'h40400000, 32'h40C00000);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_rdy", {31'd0, rdy}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_m", m, 32'd0);
    q.delete();
    held_m = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    run(32'hC0000000, 32'h40800000, 32'hC1000000);

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        ra[30:23] = 8'($urandom_range(64, 190));
        rb[30:23] = 8'($urandom_range(64, 190));
      end
      if ($urandom_range(0, 9) == 0) ra[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      if ($urandom_range(0, 9) == 0) ra[22:0] = ($urandom_range(0, 1) == 0) ? 23'd0 : 23'h7FFFFF;
      issue(ra, rb, ref_mul(ra, rb));
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
